// File: rtl/riv_up_counter.sv
// rtl/riv_up_counter.sv - elapsed-cycle up counter from 4-bit ripple stages, optional RIV_UP_COUNTER_LIMIT_EN auto-stop
module riv_up_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             enable,
`ifdef RIV_UP_COUNTER_LIMIT_EN
    input  logic [WIDTH-1:0] limit,
    output logic             timeout,
`endif
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             saturated,
    output logic [WIDTH-1:0] result,
    output logic             result_sat,
    output logic             result_valid,
    input  logic             result_ready
);

    localparam int N_STAGE = (WIDTH + 3) / 4;
    localparam int PW      = N_STAGE * 4;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_RESULT} state_t;

    state_t           state_q, state_d;
    logic [3:0]       stage_q [N_STAGE];
    logic [3:0]       stage_d [N_STAGE];
    logic [N_STAGE:0] carry;
    logic [PW-1:0]    count_pad;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_sat_q, result_sat_d;
    logic             result_valid_q, result_valid_d;
    logic             inc, clr, capture, release_res, stop_evt, limit_hit;

    always_comb begin
        count_pad = '0;
        for (int i = 0; i < N_STAGE; i++) begin
            count_pad[4*i +: 4] = stage_q[i];
        end
    end

    // Padding bits never become nonzero because counting halts at 2^WIDTH-1.
    assign count     = count_pad[WIDTH-1:0];
    assign saturated = (count == {WIDTH{1'b1}});
    assign running   = (state_q == ST_RUN);

`ifdef RIV_UP_COUNTER_LIMIT_EN
    logic timeout_q, timeout_d;
    assign limit_hit = (count == limit);
    assign timeout   = timeout_q;
`else
    assign limit_hit = 1'b0;
`endif
    assign stop_evt = stop | limit_hit;

    always_comb begin
        state_d     = state_q;
        inc         = 1'b0;
        clr         = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_evt) begin
                    capture = 1'b1;
                    state_d = ST_RESULT;
                end else if (start) begin
                    clr = 1'b1;
                end else begin
                    inc = enable & ~saturated;
                end
            end
            ST_RESULT: begin
                if (result_ready) begin
                    release_res = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A stage steps only when every lower stage is at F, so all wrap together.
    always_comb begin
        carry[0] = inc;
        for (int i = 0; i < N_STAGE; i++) begin
            carry[i+1] = carry[i] & (stage_q[i] == 4'hF);
            stage_d[i] = clr ? 4'h0 : stage_q[i] + {3'b000, carry[i]};
        end
    end

    always_comb begin
        result_d       = capture ? count : result_q;
        result_sat_d   = capture ? saturated : result_sat_q;
        result_valid_d = result_valid_q;
        if (capture)          result_valid_d = 1'b1;
        else if (release_res) result_valid_d = 1'b0;
`ifdef RIV_UP_COUNTER_LIMIT_EN
        timeout_d = timeout_q;
        if (capture)          timeout_d = limit_hit;
        else if (release_res) timeout_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            result_q       <= '0;
            result_sat_q   <= 1'b0;
            result_valid_q <= 1'b0;
            for (int i = 0; i < N_STAGE; i++) stage_q[i] <= 4'h0;
`ifdef RIV_UP_COUNTER_LIMIT_EN
            timeout_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            result_q       <= result_d;
            result_sat_q   <= result_sat_d;
            result_valid_q <= result_valid_d;
            for (int i = 0; i < N_STAGE; i++) stage_q[i] <= stage_d[i];
`ifdef RIV_UP_COUNTER_LIMIT_EN
            timeout_q      <= timeout_d;
`endif
        end
    end

    assign result       = result_q;
    assign result_sat   = result_sat_q;
    assign result_valid = result_valid_q;

endmodule

// File: doc/riv_up_counter.md
Name: riv_up_counter

Overview:
- Configurable-width elapsed-cycle counter built from 4-bit ripple stages that count **up** from zero.
- Measures the interval between a start and a stop event, counting only cycles where enable is high.
- On stop it captures the count into a result register and offers it on a valid/ready handshake.
- Used by link-training and latency-measurement logic, alongside the existing countdown timers.

Parameters:
- WIDTH, 16, counter/result width in bits; internally padded up to a multiple of 4 (N_STAGE = (WIDTH+3)/4).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  begin a measurement (pulse)
- stop  input  1  end a measurement and capture the count (pulse)
- enable  input  1  count qualifier; the counter increments only in cycles where this is high
- count  output  WIDTH  live counter value
- running  output  1  high while in the RUN state
- saturated  output  1  live count has reached 2^WIDTH-1
- result  output  WIDTH  captured count
- result_sat  output  1  saturated flag captured with result
- result_valid  output  1  result available
- result_ready  input  1  consumer accepts the result

Behaviour:
- Reset (rst_n low at a clk edge) sets: state IDLE, count=0, result=0, result_sat=0, result_valid=0, running=0, saturated=0. This applies at any point, including mid-measurement or with a result pending.
- Stage structure:
  - Stage 0 (bits 3:0) increments when inc = running & enable & ~saturated.
  - Stage i increments only when inc is high and all lower stages hold 4'hF; it then wraps to 0 together with them.
  - The carry chain is combinational; count updates on the clock edge after inc.
  - Padded upper bits are always 0 and are not visible on count.
- Saturation:
  - saturated = (count == 2^WIDTH-1), combinational from count.
  - Once saturated, the count holds; it never wraps.
- FSM states: IDLE, RUN, RESULT.
- IDLE:
  - start=1 → next cycle count=0, state RUN, running=1.
  - stop alone is ignored.
  - start and stop together → start wins, stop ignored.
- RUN:
  - The count increments per inc.
  - stop=1 → result <= count (the value before this cycle's increment; the stop cycle is not counted), result_sat <= saturated.
  - Same edge: result_valid=1, state RESULT, running=0, count frozen.
  - start=1 without stop in RUN → restart: count=0, stay in RUN.
  - start and stop together in RUN → stop wins (capture).
- RESULT:
  - result_valid is held high; result and result_sat are held stable until the handshake.
  - result_valid & result_ready at an edge → result_valid=0, state IDLE.
  - start while in RESULT is ignored; no loss of result.
  - start and result_ready together → handshake completes and the start is ignored. The initiator must re-issue start in IDLE.
- count in IDLE holds its last value until the next start.
- Latency: start→running = 1 cycle; stop→result_valid = 1 cycle.

Optional Feature:
- Macro: RIV_UP_COUNTER_LIMIT_EN
- With the macro defined, two ports are added:
  - limit (input, WIDTH): timeout value.
  - timeout (output, 1): reset 0.
- Limit behaviour in RUN:
  - When count == limit, the block auto-stops on that edge, exactly as if stop were asserted. result = limit.
  - timeout is high in the same cycle as result_valid and is cleared on the handshake.
  - A limit of 0 captures 0 on the first RUN cycle.
- Without the macro: no limit or timeout ports; only an explicit stop ends the measurement.

Test Plan:
- WIDTH=16, start, enable held 1, stop after 300 RUN cycles → result=16'd300, result_sat=0, result_valid=1 exactly one cycle after stop.
- Nibble ripple: enable=1 and observe count go 0x000F→0x0010 and 0x0FFF→0x1000 in one edge each; upper stages do not change earlier.
- WIDTH=8 (and WIDTH=6 for padding), run past 255 (63): count sticks at 0xFF (0x3F), saturated=1; stop → result=0xFF (0x3F), result_sat=1.
- enable toggled 1,0 alternately for 20 RUN cycles, then stop → result=10. result_ready held 0 for 5 cycles with start pulses → result stays 10, state RESULT. Then ready=1 → result_valid=0, IDLE.
- rst_n low for 1 cycle mid-RUN at count=0x0123, and again with result_valid pending → all outputs return to reset values the next cycle. A subsequent start counts from 0.
- RIV_UP_COUNTER_LIMIT_EN with limit=16'd50, no stop → result=50, timeout=1, result_valid=1. With limit=0 → result=0 one cycle after entering RUN.
